// File: rtl/wb_ibus_prefetch.sv
// Single-line, critical-word-first prefetch buffer for the instruction Wishbone path.
// Classic CPU reads become wrapping bursts toward the SDRAM ibus port; writes pass through and are merged.
module wb_ibus_prefetch #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [AW-1:0]   s_adr_i,
    input  logic [DW-1:0]   s_dat_i,
    input  logic [DW/8-1:0] s_sel_i,
    input  logic            s_we_i,
    input  logic            s_cyc_i,
    input  logic            s_stb_i,
    input  logic [2:0]      s_cti_i,
    input  logic [1:0]      s_bte_i,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_ack_o,
    output logic [AW-1:0]   m_adr_o,
    output logic [DW-1:0]   m_dat_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_we_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic [2:0]      m_cti_o,
    output logic [1:0]      m_bte_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            invalidate_i
);

    localparam int unsigned SW    = DW / 8;
    localparam int unsigned WORDW = $clog2(LINE_WORDS);
    localparam int unsigned OFFW  = WORDW + 2;
    localparam int unsigned TAGW  = AW - OFFW;
    localparam logic [WORDW-1:0] LAST_BEAT = WORDW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              discard_q, discard_d;
    logic [TAGW-1:0]   tag_q, tag_d;
    logic [TAGW-1:0]   fill_tag_q, fill_tag_d;
    logic [WORDW-1:0]  req_word_q, req_word_d;
    logic [WORDW-1:0]  beat_q, beat_d;
    logic [DW-1:0]     line_q [LINE_WORDS];

    logic [DW-1:0]     s_dat_d;
    logic              s_ack_d;
    logic [AW-1:0]     m_adr_d;
    logic [DW-1:0]     m_dat_d;
    logic [SW-1:0]     m_sel_d;
    logic              m_we_d, m_cyc_d, m_stb_d;
    logic [2:0]        m_cti_d;
    logic [1:0]        m_bte_d;

    logic              line_we;
    logic [WORDW-1:0]  line_idx;
    logic [DW-1:0]     line_data;
    logic [SW-1:0]     line_be;

    logic              req, hit;
    logic [TAGW-1:0]   adr_tag;
    logic [WORDW-1:0]  adr_word, fill_word, next_word;

    // Burst type, cycle type and offset bits of the CPU address carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s_cti_i, s_bte_i, s_adr_i[1:0]};

    assign req       = s_cyc_i & s_stb_i & ~s_ack_o;
    assign adr_tag   = s_adr_i[AW-1:OFFW];
    assign adr_word  = s_adr_i[OFFW-1:2];
    assign hit       = valid_q & (tag_q == adr_tag) & ~invalidate_i;
    assign fill_word = WORDW'(req_word_q + beat_q);
    assign next_word = WORDW'(fill_word + 1'b1);

    // Next-state, next-output and line-write control
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        discard_d  = discard_q;
        tag_d      = tag_q;
        fill_tag_d = fill_tag_q;
        req_word_d = req_word_q;
        beat_d     = beat_q;
        s_dat_d    = s_dat_o;
        s_ack_d    = 1'b0;
        m_adr_d    = m_adr_o;
        m_dat_d    = m_dat_o;
        m_sel_d    = m_sel_o;
        m_we_d     = m_we_o;
        m_cyc_d    = m_cyc_o;
        m_stb_d    = m_stb_o;
        m_cti_d    = m_cti_o;
        m_bte_d    = m_bte_o;
        line_we    = 1'b0;
        line_idx   = fill_word;
        line_data  = m_dat_i;
        line_be    = '1;

        unique case (state_q)
            IDLE: begin
                if (invalidate_i) valid_d = 1'b0;
                if (req) begin
                    if (s_we_i) begin
                        state_d = WRITE;
                        m_cyc_d = 1'b1;
                        m_stb_d = 1'b1;
                        m_we_d  = 1'b1;
                        m_adr_d = {s_adr_i[AW-1:2], 2'b00};
                        m_dat_d = s_dat_i;
                        m_sel_d = s_sel_i;
                        m_cti_d = 3'b000;
                        m_bte_d = 2'b00;
                    end else if (hit) begin
                        s_ack_d = 1'b1;
                        s_dat_d = line_q[adr_word];
                    end else begin
                        state_d    = FILL;
                        fill_tag_d = adr_tag;
                        req_word_d = adr_word;
                        beat_d     = '0;
                        discard_d  = 1'b0;
                        m_cyc_d    = 1'b1;
                        m_stb_d    = 1'b1;
                        m_we_d     = 1'b0;
                        m_sel_d    = '1;
                        m_adr_d    = {adr_tag, adr_word, 2'b00};
                        m_cti_d    = (LAST_BEAT == '0) ? 3'b111 : 3'b010;
                        m_bte_d    = 2'b01;
                    end
                end
            end
            FILL: begin
                if (invalidate_i) discard_d = 1'b1;
                if (m_ack_i) begin
                    line_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        m_cyc_d = 1'b0;
                        m_stb_d = 1'b0;
                        m_cti_d = 3'b000;
                        m_bte_d = 2'b00;
                        tag_d   = fill_tag_q;
                        valid_d = ~(discard_q | invalidate_i);
                    end else begin
                        beat_d  = WORDW'(beat_q + 1'b1);
                        m_adr_d = {fill_tag_q, next_word, 2'b00};
                        m_cti_d = (WORDW'(beat_q + 1'b1) == LAST_BEAT) ? 3'b111 : 3'b010;
                    end
                end
            end
            WRITE: begin
                if (invalidate_i) valid_d = 1'b0;
                if (m_ack_i) begin
                    state_d = IDLE;
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    m_we_d  = 1'b0;
                    s_ack_d = 1'b1;
                    // Keep the cached copy coherent with the write that just completed
                    if (valid_q && !invalidate_i && (m_adr_o[AW-1:OFFW] == tag_q)) begin
                        line_we   = 1'b1;
                        line_idx  = m_adr_o[OFFW-1:2];
                        line_data = m_dat_o;
                        line_be   = m_sel_o;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
            tag_q      <= '0;
            fill_tag_q <= '0;
            req_word_q <= '0;
            beat_q     <= '0;
            s_dat_o    <= '0;
            s_ack_o    <= 1'b0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            m_sel_o    <= '0;
            m_we_o     <= 1'b0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_cti_o    <= 3'b000;
            m_bte_o    <= 2'b00;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            discard_q  <= discard_d;
            tag_q      <= tag_d;
            fill_tag_q <= fill_tag_d;
            req_word_q <= req_word_d;
            beat_q     <= beat_d;
            s_dat_o    <= s_dat_d;
            s_ack_o    <= s_ack_d;
            m_adr_o    <= m_adr_d;
            m_dat_o    <= m_dat_d;
            m_sel_o    <= m_sel_d;
            m_we_o     <= m_we_d;
            m_cyc_o    <= m_cyc_d;
            m_stb_o    <= m_stb_d;
            m_cti_o    <= m_cti_d;
            m_bte_o    <= m_bte_d;
        end
    end

    // Line data, byte-lane write enables; validity is tracked by valid_q alone
    always_ff @(posedge wb_clk) begin
        for (int unsigned b = 0; b < SW; b++) begin
            if (line_we && line_be[b]) line_q[line_idx][8*b +: 8] <= line_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_wb_ibus_prefetch.sv
// Directed bench for wb_ibus_prefetch: CPU-side tasks, a zero/one-wait memory slave and a beat log.
module tb_wb_ibus_prefetch;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] s_adr_i = '0, s_dat_i = '0;
    logic [3:0]  s_sel_i = '0;
    logic        s_we_i = 1'b0, s_cyc_i = 1'b0, s_stb_i = 1'b0;
    logic [2:0]  s_cti_i = '0;
    logic [1:0]  s_bte_i = '0;
    logic [31:0] s_dat_o;
    logic        s_ack_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic [2:0]  m_cti_o;
    logic [1:0]  m_bte_o;
    logic [31:0] m_dat_i = '0;
    logic        m_ack_i = 1'b0;
    logic        invalidate_i = 1'b0;

    wb_ibus_prefetch dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_we_i(s_we_i),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_cti_i(s_cti_i), .s_bte_i(s_bte_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_cti_o(m_cti_o), .m_bte_o(m_bte_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .invalidate_i(invalidate_i)
    );

    always #5 wb_clk = ~wb_clk;

    int cycle = 0;
    always @(posedge wb_clk) cycle <= cycle + 1;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] cyc;
    } beat_t;

    beat_t       beats[$];
    beat_t       slv_b;
    logic [31:0] mem [256];
    bit          slow = 1'b0;
    bit          wait_done = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Memory slave: acks every cycle (or every other cycle when slow), logs each acked beat
    always @(negedge wb_clk) begin
        if (m_cyc_o && m_stb_o) begin
            if (slow && !wait_done) begin
                m_ack_i   = 1'b0;
                wait_done = 1'b1;
            end else begin
                wait_done = 1'b0;
                m_ack_i   = 1'b1;
                m_dat_i   = mem[m_adr_o[9:2]];
                slv_b.adr = m_adr_o;
                slv_b.dat = m_dat_o;
                slv_b.cti = m_cti_o;
                slv_b.bte = m_bte_o;
                slv_b.we  = m_we_o;
                slv_b.sel = m_sel_o;
                slv_b.cyc = 32'(cycle);
                beats.push_back(slv_b);
                if (m_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (m_sel_o[b]) mem[m_adr_o[9:2]][8*b +: 8] = m_dat_o[8*b +: 8];
                end
            end
        end else begin
            m_ack_i   = 1'b0;
            wait_done = 1'b0;
        end
    end

    function automatic int last_beat_cyc();
        return (beats.size() > 0) ? int'(beats[beats.size()-1].cyc) : -100;
    endfunction

    task automatic cpu_access(input string tag, input logic we, input logic [31:0] adr,
                              input logic [31:0] wdat, input logic [3:0] sel,
                              output logic [31:0] rdat, output int start_cyc, output int ack_cyc);
        bit got = 1'b0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        s_adr_i = adr; s_dat_i = wdat; s_sel_i = sel; s_we_i = we;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
        start_cyc = cycle;
        ack_cyc = -1;
        rdat = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge wb_clk);
            #1;
            if (s_ack_o) begin
                got = 1'b1;
                rdat = s_dat_o;
                ack_cyc = cycle;
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        check({tag, "_acked"}, 32'(got), 32'd1);
    endtask

    task automatic check_burst(input string tag, input logic [31:0] line, input int first, input int idx0);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b = (idx0 + k < beats.size()) ? beats[idx0 + k] : '0;
            check($sformatf("%s_adr%0d", tag, k), b.adr, line + 32'(((first + k) % 4) * 4));
            check($sformatf("%s_cti%0d", tag, k), 32'(b.cti), (k == 3) ? 32'd7 : 32'd2);
            check($sformatf("%s_bte%0d", tag, k), 32'(b.bte), 32'd1);
            check($sformatf("%s_we%0d", tag, k), 32'(b.we), 32'd0);
        end
    endtask

    task automatic pulse_inv_at(input logic [31:0] adr);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge wb_clk);
            #1;
            if (m_cyc_o && m_adr_o == adr) begin
                invalidate_i = 1'b1;
                @(posedge wb_clk);
                #1;
                invalidate_i = 1'b0;
                done = 1'b1;
            end
        end
        check("t5_inv_issued", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int st, ak, lc;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i * 4);
        mem[32'h114 >> 2] = 32'hFFFF_FFFF;

        // Reset values
        repeat (3) @(negedge wb_clk);
        check("rst_s_ack", 32'(s_ack_o), 32'd0);
        check("rst_s_dat", s_dat_o, 32'd0);
        check("rst_m_cyc", 32'(m_cyc_o), 32'd0);
        check("rst_m_stb", 32'(m_stb_o), 32'd0);
        check("rst_m_adr", m_adr_o, 32'd0);
        wb_rst_n = 1'b1;

        // 1: cold miss at 0x100, word-0 first
        beats.delete();
        cpu_access("t1", 1'b0, 32'h100, '0, 4'hF, rd, st, ak);
        check("t1_nbeats", 32'(beats.size()), 32'd4);
        check_burst("t1", 32'h100, 0, 0);
        check("t1_data", rd, 32'h1000_0100);
        check("t1_lat", 32'(ak - last_beat_cyc()), 32'd2);

        // 2: hit in the filled line
        beats.delete();
        cpu_access("t2", 1'b0, 32'h108, '0, 4'hF, rd, st, ak);
        check("t2_nbeats", 32'(beats.size()), 32'd0);
        check("t2_data", rd, 32'h1000_0108);
        check("t2_lat", 32'(ak - st), 32'd1);

        // 3: mid-line miss with a wait-stated slave, wraps from word 3
        beats.delete();
        slow = 1'b1;
        cpu_access("t3", 1'b0, 32'h11C, '0, 4'hF, rd, st, ak);
        slow = 1'b0;
        check("t3_nbeats", 32'(beats.size()), 32'd4);
        check_burst("t3", 32'h110, 3, 0);
        check("t3_data", rd, 32'h1000_011C);
        check("t3_lat", 32'(ak - last_beat_cyc()), 32'd2);

        // 4: partial write into the cached line, then hit on merged word
        beats.delete();
        cpu_access("t4w", 1'b1, 32'h114, 32'hAABB_CCDD, 4'b0011, rd, st, ak);
        check("t4_nbeats", 32'(beats.size()), 32'd1);
        check("t4_adr", beats.size() > 0 ? beats[0].adr : '0, 32'h114);
        check("t4_cti", beats.size() > 0 ? 32'(beats[0].cti) : 32'hFF, 32'd0);
        check("t4_bte", beats.size() > 0 ? 32'(beats[0].bte) : 32'hFF, 32'd0);
        check("t4_we", beats.size() > 0 ? 32'(beats[0].we) : '0, 32'd1);
        check("t4_sel", beats.size() > 0 ? 32'(beats[0].sel) : '0, 32'h3);
        check("t4_dat", beats.size() > 0 ? beats[0].dat : '0, 32'hAABB_CCDD);
        check("t4_wlat", 32'(ak - last_beat_cyc()), 32'd1);
        check("t4_mem", mem[32'h114 >> 2], 32'hFFFF_CCDD);
        beats.delete();
        cpu_access("t4r", 1'b0, 32'h114, '0, 4'hF, rd, st, ak);
        check("t4r_nbeats", 32'(beats.size()), 32'd0);
        check("t4r_data", rd, 32'hFFFF_CCDD);
        check("t4r_lat", 32'(ak - st), 32'd1);
        cpu_access("t4r2", 1'b0, 32'h110, '0, 4'hF, rd, st, ak);
        check("t4r2_data", rd, 32'h1000_0110);

        // 5: invalidate during beat 2 forces a second full burst
        beats.delete();
        fork
            cpu_access("t5", 1'b0, 32'h200, '0, 4'hF, rd, st, ak);
            pulse_inv_at(32'h208);
        join
        check("t5_nbeats", 32'(beats.size()), 32'd8);
        check_burst("t5a", 32'h200, 0, 0);
        check_burst("t5b", 32'h200, 0, 4);
        check("t5_data", rd, 32'h1000_0200);
        check("t5_lat", 32'(ak - last_beat_cyc()), 32'd2);

        // 6: asynchronous reset mid-fill, then the old line must miss
        @(posedge wb_clk);
        @(negedge wb_clk);
        s_adr_i = 32'h300; s_we_i = 1'b0; s_sel_i = 4'hF; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge wb_clk);
            #1;
            if (m_cyc_o) seen = 1'b1;
        end
        check("t6_fill_started", 32'(seen), 32'd1);
        @(posedge wb_clk);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check("t6_rst_m_cyc", 32'(m_cyc_o), 32'd0);
        check("t6_rst_m_stb", 32'(m_stb_o), 32'd0);
        check("t6_rst_s_ack", 32'(s_ack_o), 32'd0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        beats.delete();
        cpu_access("t6", 1'b0, 32'h200, '0, 4'hF, rd, st, ak);
        check("t6_nbeats", 32'(beats.size()), 32'd4);
        check_burst("t6", 32'h200, 0, 0);
        check("t6_data", rd, 32'h1000_0200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
